// File: rtl/div_pkg.sv
// div_pkg: shared types and sizing for the shift/subtract divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DIV_WIDTH = 8;
  localparam int CNT_W = $clog2(DIV_WIDTH);
endpackage

// File: rtl/trial_subtractor.sv
// trial_subtractor: (WIDTH+1)-bit ripple subtract a - m as a + ~m + 1, borrow is the result MSB
module trial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] m,
  output logic [WIDTH:0] diff,
  output logic           borrow
);
  logic [WIDTH:0] c;
  logic [WIDTH:0] mn;
  assign mn = ~m;
  assign c[0] = 1'b1;
  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign diff[i] = a[i] ^ mn[i] ^ c[i];
    if (i < WIDTH) begin : g_c
      assign c[i+1] = (a[i] & mn[i]) | (c[i] & (a[i] ^ mn[i]));
    end
  end
  assign borrow = diff[WIDTH];
endmodule

// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential unsigned restoring divider, one quotient bit per clock
module shift_sub_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_t         state;
  logic [WIDTH:0] a, a_sh, a_n, diff;
  logic [WIDTH-1:0] q, q_n, m;
  logic [CW-1:0]  count;
  logic           borrow;
  assign a_sh = (a << 1) | (WIDTH+1)'(q[WIDTH-1]);
  trial_subtractor #(.WIDTH(WIDTH)) u_sub (
    .a(a_sh),
    .m({1'b0, m}),
    .diff(diff),
    .borrow(borrow)
  );
  // a negative trial result restores the shifted remainder
  assign a_n = borrow ? a_sh : diff;
  assign q_n = {q[WIDTH-2:0], ~borrow};
  assign Busy = (state == CALC);
  assign Done = (state == DONE);
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      a         <= '0;
      q         <= '0;
      m         <= '0;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else if (state == IDLE) begin
      if (Run) begin
        state     <= CALC;
        a         <= '0;
        q         <= Dividend;
        m         <= Divisor;
        count     <= '0;
        DivByZero <= (Divisor == '0);
      end
    end else if (state == CALC) begin
      a     <= a_n;
      q     <= q_n;
      count <= count + CW'(1);
      if (count == CW'(WIDTH-1)) begin
        state     <= DONE;
        Quotient  <= q_n;
        Remainder <= a_n[WIDTH-1:0];
      end
    end else begin
      if (!Run) state <= IDLE;
    end
  end
endmodule
